// File: rtl/fme_sel_pkg.sv
// Shared helpers for the FME bank-select pipeline: lane width, select decode
// and the legacy 3:1 code map.
package fme_sel_pkg;

    localparam int MAX_SEL_W = 8;

    // Legacy 2-bit code -> bank, two bits per code: 00->0, 01->0, 10->1, 11->2.
    localparam logic [7:0] LEGACY_MAP = 8'b10_01_00_00;

    typedef struct packed {
        logic                 legal;
        logic [MAX_SEL_W-1:0] bank;
    } sel_dec_t;

    function automatic int calc_lw(input int data_width);
        return data_width + 2;
    endfunction

    function automatic sel_dec_t decode_sel(
        input logic [MAX_SEL_W-1:0] sel,
        input logic                 legacy,
        input int                   banks
    );
        sel_dec_t dec;
        dec.legal = 1'b1;
        dec.bank  = sel;
        if (legacy) begin
            dec.bank = {{(MAX_SEL_W-2){1'b0}}, LEGACY_MAP[{sel[1:0], 1'b0} +: 2]};
        end else if (32'(sel) >= 32'(banks)) begin
            dec.legal = 1'b0;
        end
        return dec;
    endfunction

endpackage

// File: rtl/fme_skid_buf.sv
// Two-entry valid/ready skid buffer; ready is a pure register output so the
// upstream never sees a combinational path from m_ready.
module fme_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         main_valid_reg;
    logic         skid_valid_reg;
    logic [W-1:0] main_data_reg;
    logic [W-1:0] skid_data_reg;
    logic         push;
    logic         drain;

    assign push  = s_valid && !skid_valid_reg;
    assign drain = main_valid_reg && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
        end else if (drain) begin
            // A full skid entry means push is blocked, so only one source can refill main.
            if (skid_valid_reg) begin
                main_data_reg  <= skid_data_reg;
                skid_valid_reg <= 1'b0;
            end else if (push) begin
                main_data_reg  <= s_data;
            end else begin
                main_valid_reg <= 1'b0;
            end
        end else if (push) begin
            if (main_valid_reg) begin
                skid_data_reg  <= s_data;
                skid_valid_reg <= 1'b1;
            end else begin
                main_data_reg  <= s_data;
                main_valid_reg <= 1'b1;
            end
        end
    end

    assign s_ready = !skid_valid_reg;
    assign m_valid = main_valid_reg;
    assign m_data  = main_data_reg;

endmodule

// File: rtl/fme_bank_select_pipe.sv
// Registered bank selector for FME candidate rows: decodes sel, forwards the
// chosen bank through a skid stage, flags illegal codes and counts usage.
module fme_bank_select_pipe
    import fme_sel_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 16,
    parameter int BANKS      = 3,
    parameter int SEL_W      = 2,
    parameter bit LEGACY_ENC = 1'b1,
    parameter int CNT_W      = 16,
    localparam int LW        = calc_lw(DATA_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEL_W-1:0]            sel,
    input  logic [BANKS*LANES*LW-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*LW-1:0]         out_data,
    output logic [SEL_W-1:0]            out_bank,
    output logic                        err_sel,
    input  logic                        cnt_clr,
    output logic [BANKS*CNT_W-1:0]      bank_cnt
);

    localparam bit LEGACY_ACTIVE = LEGACY_ENC && (BANKS == 3) && (SEL_W == 2);
    localparam int RW            = LANES * LW;
    localparam int PW            = SEL_W + RW;

    sel_dec_t          dec;
    logic [SEL_W-1:0]  dec_bank;
    logic [RW-1:0]     mux_data;
    logic              accept;
    logic              err_sel_reg;
    logic [PW-1:0]     payload;

    always_comb begin
        dec      = decode_sel(MAX_SEL_W'(sel), LEGACY_ACTIVE, BANKS);
        dec_bank = dec.bank[SEL_W-1:0];
        mux_data = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (dec_bank == SEL_W'(b)) begin
                mux_data = in_data[b*RW +: RW];
            end
        end
    end

    assign accept = in_valid && in_ready;

    // Illegal beats still consume the handshake but never enter the buffer.
    fme_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (in_valid && dec.legal),
        .s_ready (in_ready),
        .s_data  ({dec_bank, mux_data}),
        .m_valid (out_valid),
        .m_ready (out_ready),
        .m_data  (payload)
    );

    assign out_bank = payload[PW-1 -: SEL_W];
    assign out_data = payload[RW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel_reg <= 1'b0;
        end else begin
            err_sel_reg <= accept && !dec.legal;
        end
    end

    assign err_sel = err_sel_reg;

    for (genvar gi = 0; gi < BANKS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        logic             hit;

        assign hit = out_valid && out_ready && (out_bank == SEL_W'(gi));

        // Clear has priority; counters stick at all-ones instead of wrapping.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (hit && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign bank_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end

endmodule

// File: tb/tb_fme_bank_select_pipe.sv
// Randomised and directed checks of fme_bank_select_pipe: a legacy-decode
// instance (16-bit counters) and a plain-decode instance (4-bit counters).
module tb_fme_bank_select_pipe;

    localparam int LW    = 10;
    localparam int LANES = 16;
    localparam int BANKS = 3;
    localparam int OW    = LANES * LW;
    localparam int IW    = BANKS * OW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            in_valid_v [2];
    logic            out_ready_v[2];
    logic            cnt_clr_v  [2];
    logic [1:0]      sel_v      [2];
    logic [IW-1:0]   in_data_v  [2];

    logic            in_ready_a, out_valid_a, err_sel_a;
    logic [OW-1:0]   out_data_a;
    logic [1:0]      out_bank_a;
    logic [47:0]     bank_cnt_a;

    logic            in_ready_b, out_valid_b, err_sel_b;
    logic [OW-1:0]   out_data_b;
    logic [1:0]      out_bank_b;
    logic [11:0]     bank_cnt_b;

    fme_bank_select_pipe #(
        .DATA_WIDTH(8), .LANES(LANES), .BANKS(BANKS), .SEL_W(2), .LEGACY_ENC(1'b1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_a), .sel(sel_v[0]),
        .in_data(in_data_v[0]), .out_valid(out_valid_a), .out_ready(out_ready_v[0]),
        .out_data(out_data_a), .out_bank(out_bank_a), .err_sel(err_sel_a),
        .cnt_clr(cnt_clr_v[0]), .bank_cnt(bank_cnt_a)
    );

    fme_bank_select_pipe #(
        .DATA_WIDTH(8), .LANES(LANES), .BANKS(BANKS), .SEL_W(2), .LEGACY_ENC(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_b), .sel(sel_v[1]),
        .in_data(in_data_v[1]), .out_valid(out_valid_b), .out_ready(out_ready_v[1]),
        .out_data(out_data_b), .out_bank(out_bank_b), .err_sel(err_sel_b),
        .cnt_clr(cnt_clr_v[1]), .bank_cnt(bank_cnt_b)
    );

    typedef struct {
        logic [1:0]    bank;
        logic [OW-1:0] data;
    } beat_t;

    beat_t        mq   [2][$];
    int unsigned  mcnt [2][3];
    logic         err_exp[2];

    int tests  = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the select rules.
    task automatic ref_decode(input int d, input logic [1:0] s, output logic legal, output logic [1:0] bank);
        int sv;
        sv = int'(s);
        if (d == 0) begin
            legal = 1'b1;
            bank  = (sv < 2) ? 2'd0 : 2'(sv - 1);
        end else begin
            legal = (sv < BANKS);
            bank  = s;
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            err_exp[d] = 1'b0;
            for (int b = 0; b < 3; b++) mcnt[d][b] = 0;
        end
    endtask

    // Compare DUT d against the model, then advance the model across the next edge.
    task automatic observe(input int d);
        logic          iready, ov, es, acc, hs, legal;
        logic [OW-1:0] od;
        logic [1:0]    ob, rb;
        logic [15:0]   c;
        int unsigned   cmax;
        beat_t         f, nb;
        if (d == 0) begin
            iready = in_ready_a; ov = out_valid_a; es = err_sel_a; od = out_data_a; ob = out_bank_a; cmax = 65535;
        end else begin
            iready = in_ready_b; ov = out_valid_b; es = err_sel_b; od = out_data_b; ob = out_bank_b; cmax = 15;
        end
        check_eq($sformatf("d%0d in_ready", d), iready, mq[d].size() < 2);
        check_eq($sformatf("d%0d out_valid", d), ov, mq[d].size() > 0);
        check_eq($sformatf("d%0d err_sel", d), es, err_exp[d]);
        if (mq[d].size() > 0) begin
            f = mq[d][0];
            check_eq($sformatf("d%0d out_data", d), od, f.data);
            check_eq($sformatf("d%0d out_bank", d), ob, f.bank);
        end
        for (int b = 0; b < 3; b++) begin
            c = (d == 0) ? bank_cnt_a[b*16 +: 16] : {12'b0, bank_cnt_b[b*4 +: 4]};
            check_eq($sformatf("d%0d bank_cnt[%0d]", d, b), c, 16'(mcnt[d][b]));
        end
        acc = in_valid_v[d] && (mq[d].size() < 2);
        hs  = (mq[d].size() > 0) && out_ready_v[d];
        err_exp[d] = 1'b0;
        if (hs) begin
            f = mq[d].pop_front();
            if (mcnt[d][f.bank] < cmax) mcnt[d][f.bank]++;
        end
        if (cnt_clr_v[d]) begin
            for (int b = 0; b < 3; b++) mcnt[d][b] = 0;
        end
        if (acc) begin
            ref_decode(d, sel_v[d], legal, rb);
            if (legal) begin
                nb.bank = rb;
                nb.data = in_data_v[d][int'(rb)*OW +: OW];
                mq[d].push_back(nb);
            end else begin
                err_exp[d] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe(0);
        observe(1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] ramp_pattern();
        logic [IW-1:0] v;
        v = '0;
        for (int b = 0; b < BANKS; b++)
            for (int l = 0; l < LANES; l++)
                v[(b*LANES + l)*LW +: LW] = LW'(b*16 + l);
        return v;
    endfunction

    function automatic logic [IW-1:0] rand_pattern();
        logic [IW-1:0] v;
        for (int i = 0; i < BANKS*LANES; i++) v[i*LW +: LW] = LW'($urandom_range(0, 1023));
        return v;
    endfunction

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0; out_ready_v[d] = 1'b1; cnt_clr_v[d] = 1'b0;
        end
    endtask

    initial begin
        logic [IW-1:0] sdata;
        logic [1:0]    legacy_codes [4];
        for (int d = 0; d < 2; d++) begin
            sel_v[d] = 2'd0; in_data_v[d] = '0;
        end
        idle_all();
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst out_valid", out_valid_a, 1'b0);
        check_eq("rst in_ready", in_ready_a, 1'b1);
        check_eq("rst out_data", out_data_a, '0);
        check_eq("rst out_bank", out_bank_a, 2'd0);
        check_eq("rst err_sel", err_sel_b, 1'b0);
        check_eq("rst bank_cnt", {bank_cnt_a, bank_cnt_b}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Legacy decode with the ramp pattern, back-to-back beats.
        legacy_codes = '{2'b00, 2'b01, 2'b10, 2'b11};
        in_data_v[0] = ramp_pattern();
        for (int i = 0; i < 4; i++) begin
            in_valid_v[0] = 1'b1;
            sel_v[0] = legacy_codes[i];
            tick();
        end
        in_valid_v[0] = 1'b0;
        tick();
        tick();

        // Illegal code then a legal one on the plain-decode instance.
        in_data_v[1] = ramp_pattern();
        in_valid_v[1] = 1'b1; sel_v[1] = 2'd3;
        tick();
        sel_v[1] = 2'd1;
        tick();
        in_valid_v[1] = 1'b0;
        tick();
        check_eq("illegal bank_cnt", bank_cnt_b, 12'h010);

        // Signed extremes must pass bit-exact.
        sdata = '0;
        for (int l = 0; l < LANES; l++) sdata[(LANES + l)*LW +: LW] = (l % 2 == 0) ? 10'h200 : 10'h1FF;
        in_data_v[1] = sdata;
        in_valid_v[1] = 1'b1; sel_v[1] = 2'd1;
        tick();
        in_valid_v[1] = 1'b0;
        check_eq("signed lane0", out_data_b[9:0], 10'h200);
        check_eq("signed lane1", out_data_b[19:10], 10'h1FF);
        tick();

        // Saturate bank 2 on the 4-bit counter instance.
        in_valid_v[1] = 1'b1; sel_v[1] = 2'd2;
        repeat (20) tick();
        in_valid_v[1] = 1'b0;
        tick();
        tick();
        check_eq("sat bank_cnt[2]", bank_cnt_b[11:8], 4'd15);
        in_valid_v[1] = 1'b1;
        tick();
        in_valid_v[1] = 1'b0; cnt_clr_v[1] = 1'b1;
        tick();
        cnt_clr_v[1] = 1'b0;
        check_eq("clr wins bank_cnt[2]", bank_cnt_b[11:8], 4'd0);

        // Random traffic with back-pressure on both instances.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid_v[d]  = ($urandom_range(0, 3) != 0);
                out_ready_v[d] = $urandom_range(0, 1) == 1;
                cnt_clr_v[d]   = ($urandom_range(0, 63) == 0);
                sel_v[d]       = 2'($urandom_range(0, 3));
                in_data_v[d]   = rand_pattern();
            end
            tick();
        end
        idle_all();
        repeat (3) tick();

        // Fill both entries, then reset mid-flight.
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b1; out_ready_v[d] = 1'b0; sel_v[d] = 2'd1; in_data_v[d] = rand_pattern();
        end
        repeat (3) tick();
        check_eq("full in_ready", in_ready_a, 1'b0);
        for (int d = 0; d < 2; d++) in_valid_v[d] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst out_valid", out_valid_a, 1'b0);
        check_eq("midrst in_ready", in_ready_a, 1'b1);
        check_eq("midrst out_valid b", out_valid_b, 1'b0);
        check_eq("midrst err_sel", err_sel_b, 1'b0);
        check_eq("midrst bank_cnt", {bank_cnt_a, bank_cnt_b}, '0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_all();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
